// File: rtl/mult_cpa_pipe_if.sv
// mult_cpa_pipe_if: valid/ready bundle for the CPA pipe.
// Input side carries sum/carry; output side carries product.
interface mult_cpa_pipe_if #(
  parameter int W = 12
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_sum;
  logic [W-1:0] in_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_prod;
  logic         out_ovf;

  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_prod, out_ovf
  );

  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_prod, out_ovf
  );
endinterface

// File: rtl/mult_cpa_pipe.sv
// mult_cpa_pipe: 2-stage carry-propagate adder merging the
// sum/carry vectors of the reduction tree, split at bit LO.
module mult_cpa_pipe #(
  parameter int W  = 12,
  parameter int LO = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  mult_cpa_pipe_if.slave   bus,
  output logic             busy
);
  localparam int HW = W - LO;

  typedef struct packed {
    logic [HW:0]   cs_hi;
    logic [HW-1:0] sum_hi;
    logic          c_lo;
    logic [LO-1:0] lo;
  } s1_t;

  logic          s1_valid;
  s1_t           s1_q;
  s1_t           s1_d;
  logic          s2_load;
  logic          s1_move;
  logic          accept;
  logic [W:0]    cs;
  logic [LO:0]   lo;
  logic [HW+1:0] hi;

  assign s2_load     = !bus.out_valid || bus.out_ready;
  assign s1_move     = s1_valid && s2_load;
  assign bus.in_ready = !s1_valid || s2_load;
  assign accept      = bus.in_valid && bus.in_ready;
  assign busy        = s1_valid | bus.out_valid;

  // Low slice add plus operand capture for the high slice.
  always_comb begin
    cs   = {bus.in_carry, 1'b0};
    lo   = {1'b0, bus.in_sum[LO-1:0]}
         + {1'b0, cs[LO-1:0]};
    s1_d = '{cs_hi:  cs[W:LO],
             sum_hi: bus.in_sum[W-1:LO],
             c_lo:   lo[LO],
             lo:     lo[LO-1:0]};
    hi   = {2'b0, s1_q.sum_hi}
         + {1'b0, s1_q.cs_hi}
         + {{(HW+1){1'b0}}, s1_q.c_lo};
  end

  // Stage 1: holds until stage 2 frees up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      s1_valid <= accept | (s1_valid & !s1_move);
      if (accept) s1_q <= s1_d;
    end
  end

  // Stage 2: output register, frozen under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_prod  <= '0;
      bus.out_ovf   <= 1'b0;
    end else if (s2_load) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_prod <= {hi[HW:0], s1_q.lo};
        bus.out_ovf  <= hi[HW+1];
      end
    end
  end
endmodule

// File: tb/tb_mult_cpa_pipe.sv
// tb_mult_cpa_pipe: directed plus random checks of the
// CPA pipe against a queue-based arithmetic model.
module tb_mult_cpa_pipe;
  localparam int W  = 12;
  localparam int LO = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  logic [13:0] exp_q[$];
  logic [13:0] last_e;

  mult_cpa_pipe_if #(.W(W)) bus ();

  mult_cpa_pipe #(.W(W), .LO(LO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] model(
    input logic [11:0] s,
    input logic [11:0] c
  );
    return {2'b0, s} + {1'b0, c, 1'b0};
  endfunction

  // Drive one cycle, sample mid-cycle, score handshakes.
  task automatic tick(
    input logic        v,
    input logic [11:0] s,
    input logic [11:0] c,
    input logic        r
  );
    logic [13:0] e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_sum    = s;
    bus.in_carry  = c;
    bus.out_ready = r;
    #1;
    check("in_ready",
          32'(bus.in_ready),
          32'(!(exp_q.size() == 2 && !r)));
    check("busy", 32'(busy), 32'(exp_q.size() != 0));
    if (bus.out_valid && r) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("spurious", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        last_e = e;
        check("prod", 32'(bus.out_prod), 32'(e[12:0]));
        check("ovf", 32'(bus.out_ovf), 32'(e[13]));
      end
    end
    if (v && bus.in_ready) exp_q.push_back(model(s, c));
  endtask

  task automatic idle(input logic r);
    tick(1'b0, 12'($urandom), 12'($urandom), r);
  endtask

  task automatic one(
    input string       tag,
    input logic [11:0] s,
    input logic [11:0] c,
    input logic [12:0] ep,
    input logic        eo
  );
    tick(1'b1, s, c, 1'b1);
    idle(1'b1);
    check({tag, "_lat"}, 32'(bus.out_valid), 32'(0));
    idle(1'b1);
    check({tag, "_vld"}, 32'(bus.out_valid), 32'(1));
    check({tag, "_prod"}, 32'(bus.out_prod), 32'(ep));
    check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(eo));
  endtask

  initial begin
    int base;
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.in_carry  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_vld", 32'(bus.out_valid), 32'(0));
    check("rst_prod", 32'(bus.out_prod), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    idle(1'b1);

    one("t1", 12'h0A5, 12'h003, 13'h00AB, 1'b0);
    one("t2", 12'h03F, 12'h001, 13'h0041, 1'b0);
    one("t3", 12'hFFF, 12'hFFF, 13'h0FFD, 1'b1);

    // Backpressure: two ops fill the pipe, third waits.
    tick(1'b1, 12'h111, 12'h001, 1'b0);
    tick(1'b1, 12'h222, 12'h002, 1'b0);
    tick(1'b1, 12'h333, 12'h003, 1'b0);
    check("bp_rdy", 32'(bus.in_ready), 32'(0));
    check("bp_hold", 32'(bus.out_prod), 32'(13'h0113));
    tick(1'b1, 12'h333, 12'h003, 1'b0);
    check("bp_hold2", 32'(bus.out_prod), 32'(13'h0113));
    base = n_out;
    tick(1'b1, 12'h333, 12'h003, 1'b1);
    idle(1'b1);
    check("bp_op2", 32'(last_e), 32'(14'h0226));
    idle(1'b1);
    check("bp_op3", 32'(last_e), 32'(14'h0339));
    check("bp_cnt", 32'(n_out - base), 32'(3));
    idle(1'b1);

    // Streaming: eight back-to-back ops, no bubbles.
    base = n_out;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        tick(1'b1, 12'($urandom), 12'($urandom), 1'b1);
        check("st_rdy", 32'(bus.in_ready), 32'(1));
      end else begin
        idle(1'b1);
      end
      check("st_vld", 32'(bus.out_valid), 32'(i >= 2));
    end
    idle(1'b1);
    check("st_cnt", 32'(n_out - base), 32'(8));

    // Reset with two ops in flight.
    tick(1'b1, 12'h0F0, 12'h00F, 1'b0);
    tick(1'b1, 12'h00F, 12'h0F0, 1'b0);
    idle(1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("rs_vld", 32'(bus.out_valid), 32'(0));
    check("rs_prod", 32'(bus.out_prod), 32'(0));
    check("rs_busy", 32'(busy), 32'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check("rs_stale", 32'(bus.out_valid), 32'(0));
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 3) != 0),
           12'($urandom), 12'($urandom),
           1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 6 && exp_q.size() != 0; i++) idle(1'b1);
    check("drain", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
